// File: rtl/datamemory_ws_if.sv
`default_nettype none
// ============================================================================
// Module   : datamemory_ws_if
// Brief    : Pipeline <-> data-memory request/response and trace bundle.
// Revision : 1.0
// ============================================================================
interface datamemory_ws_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
);
    logic              MemRead;
    logic              MemWrite;
    logic [2:0]        Funct3;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] wd;
    logic              stall;
    logic              valid;
    logic [DATA_W-1:0] rdata;
    logic              misalign;
    logic              wr;
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output MemRead, MemWrite, Funct3, a, wd,
        input  stall, valid, rdata, misalign, wr, rd, addr, wr_data, rd_data
    );

    modport slave (
        input  MemRead, MemWrite, Funct3, a, wd,
        output stall, valid, rdata, misalign, wr, rd, addr, wr_data, rd_data
    );
endinterface
`default_nettype wire

// File: rtl/datamemory_ws.sv
`default_nettype none
// ============================================================================
// Module   : datamemory_ws
// Brief    : Data memory with configurable wait states, b/h/w access sizes
//            and a stall/valid handshake toward the pipeline.
// Revision : 1.0
// ============================================================================
module datamemory_ws #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 9,
    parameter int WAIT_CYCLES = 2
) (
    input  wire logic       clk,
    input  wire logic       reset,
    datamemory_ws_if.slave  bus
);

    localparam int         c_IDX_W     = ADDR_W - 2;
    localparam int         c_DEPTH     = 1 << c_IDX_W;
    localparam logic [3:0] c_WAIT_INIT = 4'(WAIT_CYCLES);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_WAIT   = 2'd1;
    localparam logic [1:0] c_ACCESS = 2'd2;

    generate
        if (DATA_W != 32) begin : g_bad_data_w
            $error("datamemory_ws: DATA_W must be 32");
        end
        if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
            $error("datamemory_ws: WAIT_CYCLES must be 0..15");
        end
    endgenerate

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [3:0]        r_cnt;
    logic              w_req;
    logic              w_accept;
    logic              w_stall;

    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wd;
    logic [2:0]        r_funct3;
    logic              r_is_store;
    logic              r_both;

    logic [DATA_W-1:0] r_mem [c_DEPTH];

    logic              r_valid;
    logic              r_misalign;
    logic              r_wr;
    logic              r_rd;
    logic [DATA_W-1:0] r_rdata;
    logic [ADDR_W-1:0] r_trace_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic [DATA_W-1:0] r_rd_data;

    logic [c_IDX_W-1:0] w_idx;
    logic [1:0]         w_off;
    logic [DATA_W-1:0]  w_word;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic               w_err;
    logic               w_err_all;
    logic [DATA_W-1:0]  w_mask;
    logic [DATA_W-1:0]  w_wdata;
    logic [DATA_W-1:0]  w_load;
    logic [DATA_W-1:0]  w_merged;
    logic               w_commit;
    logic               w_load_ok;

    assign w_req    = bus.MemRead | bus.MemWrite;
    // The valid cycle is the pipeline-advance cycle; the still-held request must not be re-accepted.
    assign w_accept = (r_state == c_IDLE) & w_req & ~r_valid;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_next_state = (c_WAIT_INIT == 4'd0) ? c_ACCESS : c_WAIT;
                end
            end
            c_WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_next_state = c_ACCESS;
                end
            end
            c_ACCESS: w_next_state = c_IDLE;
            default:  w_next_state = c_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_stall = w_accept | (r_state == c_WAIT) | (r_state == c_ACCESS);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= 4'd0;
        end else if (w_accept) begin
            r_cnt <= c_WAIT_INIT;
        end else if (r_state == c_WAIT) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr     <= '0;
            r_wd       <= '0;
            r_funct3   <= 3'd0;
            r_is_store <= 1'b0;
            r_both     <= 1'b0;
        end else if (w_accept) begin
            r_addr     <= bus.a;
            r_wd       <= bus.wd;
            r_funct3   <= bus.Funct3;
            r_is_store <= bus.MemWrite;
            r_both     <= bus.MemRead & bus.MemWrite;
        end
    end

    assign w_idx  = r_addr[ADDR_W-1:2];
    assign w_off  = r_addr[1:0];
    assign w_word = r_mem[w_idx];
    assign w_byte = w_word[{w_off, 3'b000} +: 8];
    assign w_half = w_off[1] ? w_word[31:16] : w_word[15:0];

    // Size/sign decode; w_mask/w_wdata place the store lanes for the read-modify-write.
    always_comb begin
        w_err   = 1'b0;
        w_mask  = '0;
        w_wdata = r_wd;
        w_load  = '0;
        case (r_funct3)
            3'b000: begin
                w_mask  = 32'h0000_00FF << {w_off, 3'b000};
                w_wdata = {4{r_wd[7:0]}};
                w_load  = {{24{w_byte[7]}}, w_byte};
            end
            3'b001: begin
                w_err   = w_off[0];
                w_mask  = w_off[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                w_wdata = {2{r_wd[15:0]}};
                w_load  = {{16{w_half[15]}}, w_half};
            end
            3'b010: begin
                w_err   = |w_off;
                w_mask  = 32'hFFFF_FFFF;
                w_load  = w_word;
            end
            3'b100: begin
                w_err   = r_is_store;
                w_load  = {24'd0, w_byte};
            end
            3'b101: begin
                w_err   = r_is_store | w_off[0];
                w_load  = {16'd0, w_half};
            end
            default: w_err = 1'b1;
        endcase
    end

    assign w_err_all = w_err | r_both;
    assign w_merged  = (w_word & ~w_mask) | (w_wdata & w_mask);
    assign w_commit  = (r_state == c_ACCESS) & r_is_store & ~w_err_all;
    assign w_load_ok = ~r_is_store & ~w_err_all;

    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid      <= 1'b0;
            r_misalign   <= 1'b0;
            r_wr         <= 1'b0;
            r_rd         <= 1'b0;
            r_rdata      <= '0;
            r_trace_addr <= '0;
            r_wr_data    <= '0;
            r_rd_data    <= '0;
        end else begin
            r_valid    <= 1'b0;
            r_misalign <= 1'b0;
            r_wr       <= 1'b0;
            r_rd       <= 1'b0;
            if (r_state == c_ACCESS) begin
                r_valid      <= 1'b1;
                r_misalign   <= w_err_all;
                r_wr         <= w_commit;
                r_rd         <= w_load_ok;
                r_rdata      <= w_load_ok ? w_load : '0;
                r_trace_addr <= r_addr;
                if (w_commit) begin
                    r_wr_data <= w_merged;
                end
                if (w_load_ok) begin
                    r_rd_data <= w_word;
                end
            end
        end
    end

    assign bus.stall    = w_stall;
    assign bus.valid    = r_valid;
    assign bus.misalign = r_misalign;
    assign bus.wr       = r_wr;
    assign bus.rd       = r_rd;
    assign bus.rdata    = r_rdata;
    assign bus.addr     = r_trace_addr;
    assign bus.wr_data  = r_wr_data;
    assign bus.rd_data  = r_rd_data;

endmodule
`default_nettype wire
